// File: rtl/fp_result_display.sv
// -----------------------------------------------------------------------------
// fp_result_display
//
// Purpose:
//   Consumes the processor's 32-bit result bus and shows the most recent
//   result as 8 hex digits on two 4-digit seven-segment banks. The banks are
//   scanned together: scan step k lights digit k on the right bank (seg0)
//   and digit k+4 on the left bank (seg1).
//
//   New results never change the display in the middle of a scan frame.
//   A strobe outside the frame wrap is parked in a pending register and
//   promoted at the next wrap. A strobe landing exactly on the wrap cycle
//   goes straight to the display. Several strobes within one frame simply
//   overwrite the pending value, so the last one wins.
//
// Parameters:
//   REFRESH_DIV    clk cycles per scan step (legal 2 .. 2**24)
//   SEG_ACTIVE_LOW 1 = seg0/seg1/anode are inverted at the output registers
//
// Optional build macro:
//   FP_DISPLAY_LZ_BLANK_EN  when defined, leading-zero digits (k > 0 with all
//                           nibbles k..7 zero) are blanked. Digit 0 is always
//                           shown and the anode scan is unaffected.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset, clears all state
//   result_in     in   [31:0] processor result word
//   result_valid  in   one-cycle strobe, result_in holds a new value
//   seg0          out  [6:0] right bank segments, bit0=a .. bit6=g
//   seg1          out  [6:0] left bank segments, bit0=a .. bit6=g
//   anode         out  [7:0] digit enables, bit k = digit k
//   frame_done    out  one-cycle pulse after the scan wraps 3 -> 0
//
// Handshake: result_valid is a strobe with no back-pressure. Every cycle in
// which it is high is one complete transfer of result_in; there is no ready.
// -----------------------------------------------------------------------------
module fp_result_display #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result_in,
  input  logic        result_valid,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [7:0]  anode,
  output logic        frame_done
);

  localparam int             CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  TC_VAL  = CW'(REFRESH_DIV - 1);
  // Output polarity masks; XOR with these applies SEG_ACTIVE_LOW.
  localparam logic [6:0]     SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [7:0]     AN_POL  = {8{SEG_ACTIVE_LOW}};

  // Scan position FSM: one state per digit pair.
  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_t;

  // ---------------------------------------------------------------------------
  // hex digit to active-high segment pattern (bit0=a .. bit6=g)
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_prescaler;
  scan_state_t   r_scan_state;
  scan_state_t   w_scan_next;
  logic [31:0]   r_disp;
  logic [31:0]   r_pend;
  logic          r_pend_flag;
  logic [6:0]    r_seg0;
  logic [6:0]    r_seg1;
  logic [7:0]    r_anode;
  logic          r_frame_done;

  logic          w_tc;
  logic          w_wrap;
  logic [1:0]    w_idx;
  logic [3:0]    w_nib_lo;
  logic [3:0]    w_nib_hi;
  logic [7:0]    w_anode_raw;
  logic          w_blank_lo;
  logic          w_blank_hi;
  logic [6:0]    w_seg0_raw;
  logic [6:0]    w_seg1_raw;

  // ---------------------------------------------------------------------------
  // Prescaler: 0 .. REFRESH_DIV-1, one scan step per full count
  // ---------------------------------------------------------------------------
  assign w_tc = (r_prescaler == TC_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
    end else if (w_tc) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_state <= SCAN_D0;
    end else begin
      r_scan_state <= w_scan_next;
    end
  end

  // Scan FSM: next state, advances only on the prescaler terminal count
  always_comb begin
    w_scan_next = r_scan_state;
    if (w_tc) begin
      case (r_scan_state)
        SCAN_D0: w_scan_next = SCAN_D1;
        SCAN_D1: w_scan_next = SCAN_D2;
        SCAN_D2: w_scan_next = SCAN_D3;
        default: w_scan_next = SCAN_D0;
      endcase
    end
  end

  // Scan FSM: outputs (digit index and frame wrap)
  always_comb begin
    w_idx  = 2'd0;
    w_wrap = 1'b0;
    case (r_scan_state)
      SCAN_D0: w_idx = 2'd0;
      SCAN_D1: w_idx = 2'd1;
      SCAN_D2: w_idx = 2'd2;
      default: begin
        w_idx  = 2'd3;
        w_wrap = w_tc;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result capture. The display register only ever changes on a wrap, which
  // keeps each frame consistent. A strobe on the wrap itself bypasses the
  // pending register and also discards any older pending value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
    end else if (w_wrap) begin
      if (result_valid) begin
        r_disp      <= result_in;
        r_pend_flag <= 1'b0;
      end else if (r_pend_flag) begin
        r_disp      <= r_pend;
        r_pend_flag <= 1'b0;
      end
    end else if (result_valid) begin
      r_pend      <= result_in;
      r_pend_flag <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection for the current scan step
  // ---------------------------------------------------------------------------
  assign w_nib_lo    = 4'(r_disp >> {w_idx, 2'b00});
  assign w_nib_hi    = 4'(r_disp >> {1'b1, w_idx, 2'b00});
  assign w_anode_raw = 8'h11 << w_idx;

`ifdef FP_DISPLAY_LZ_BLANK_EN
  // w_lz_tail[k] is set when nibbles k..7 of the display word are all zero.
  logic [7:0] w_lz_tail;

  always_comb begin
    w_lz_tail    = '0;
    w_lz_tail[7] = (r_disp[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--) begin
      w_lz_tail[k] = w_lz_tail[k+1] && (r_disp[4*k +: 4] == 4'h0);
    end
  end

  // Digit 0 is never blanked; the left bank digit is always index >= 4.
  assign w_blank_lo = (w_idx != 2'd0) && w_lz_tail[{1'b0, w_idx}];
  assign w_blank_hi = w_lz_tail[{1'b1, w_idx}];
`else
  assign w_blank_lo = 1'b0;
  assign w_blank_hi = 1'b0;
`endif

  assign w_seg0_raw = w_blank_lo ? 7'h00 : hex7(w_nib_lo);
  assign w_seg1_raw = w_blank_hi ? 7'h00 : hex7(w_nib_hi);

  // ---------------------------------------------------------------------------
  // Output registers: one cycle behind the scan state. Reset value is the
  // inactive level, which flips with SEG_ACTIVE_LOW.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg0       <= SEG_POL;
      r_seg1       <= SEG_POL;
      r_anode      <= AN_POL;
      r_frame_done <= 1'b0;
    end else begin
      r_seg0       <= w_seg0_raw ^ SEG_POL;
      r_seg1       <= w_seg1_raw ^ SEG_POL;
      r_anode      <= w_anode_raw ^ AN_POL;
      r_frame_done <= w_wrap;
    end
  end

  assign seg0       = r_seg0;
  assign seg1       = r_seg1;
  assign anode      = r_anode;
  assign frame_done = r_frame_done;

endmodule

// File: doc/fp_result_display.md
Name: fp_result_display

Overview:
- Downstream consumer of the processor's 32-bit `result` bus.
- Latches a new result on a valid strobe and displays it as 8 hex digits on two 4-digit seven-segment banks (seg0 = digits 0-3, seg1 = digits 4-7), time-multiplexed via an 8-bit anode bus.
- Display updates are deferred to frame boundaries so a digit scan never shows a mix of old and new values.

Parameters:
- REFRESH_DIV, 100000, clk cycles per scan step (1 kHz step at 100 MHz); legal range 2..2^24.
- SEG_ACTIVE_LOW, 0, 1 inverts seg0/seg1 and anode at the output registers.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- result_in  in  32  processor result word
- result_valid  in  1  one-cycle strobe: result_in is a new value
- seg0  out  7  right bank segments, bit0=a .. bit6=g
- seg1  out  7  left bank segments, bit0=a .. bit6=g
- anode  out  8  digit enables, bit k = digit k (digit 0 rightmost)
- frame_done  out  1  one-cycle pulse when the scan wraps 3->0

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - prescaler=0, scan_idx=0, disp_reg=0, pend_reg=0, pend_flag=0.
  - seg0=seg1=0, anode=0, frame_done=0; all outputs in the inactive state, inverted when SEG_ACTIVE_LOW=1.
- Prescaler: counts 0..REFRESH_DIV-1. Terminal count (tc) = count==REFRESH_DIV-1; on tc it reloads to 0 and scan_idx increments mod 4.
- Wrap = tc with scan_idx==3. On wrap:
  - frame_done=1 next cycle.
  - If result_valid is high in the same cycle, disp_reg<=result_in and pend_flag<=0.
  - Else if pend_flag, disp_reg<=pend_reg and pend_flag<=0.
- result_valid outside a wrap cycle: pend_reg<=result_in, pend_flag<=1. Back-to-back strobes overwrite; the last value wins.
- Output registers, 1-cycle latency from scan_idx:
  - anode = one-hot with bits scan_idx and scan_idx+4 set.
  - seg0 = hex7(disp_reg[4k+3:4k]); seg1 = hex7(disp_reg[4k+19:4k+16]); k = scan_idx.
- hex7 (active-high, 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- First valid output: the cycle after reset deassert, anode=0x11, segs=hex7(0)=0x3F.
- Reset mid-frame: all state cleared immediately, including any pending value; the scan restarts at index 0.
- result_valid during reset is ignored.

Optional Feature:
- Macro: FP_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k is blanked (seg=0 before polarity) when all nibbles k..7 of disp_reg are zero and k>0. Digit 0 is always shown.
  - The anode still scans normally.
  - The blank mask is computed from disp_reg and registered alongside seg, so latency is unchanged.
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset release, REFRESH_DIV=4: first cycle anode=0x11, seg0=seg1=0x3F; anode steps 0x11->0x22->0x44->0x88->0x11 every 4 cycles; frame_done pulses every 16 cycles.
- result_valid with 0x12345678 mid-frame: display unchanged until the next frame_done; the following frame shows step0 seg0=hex7(8)=0x7F, seg1=hex7(4)=0x66; step3 seg0=hex7(5)=0x6D, seg1=hex7(1)=0x06.
- Strobes 0xAAAAAAAA then 0xDEADBEEF within one frame: only 0xDEADBEEF is displayed after the wrap; 0xAAAAAAAA never appears.
- result_valid with 0xCAFEF00D coincident with the wrap cycle: shown in the frame that starts immediately; pend_flag is 0 afterwards.
- Reset asserted mid-frame with a pending value: outputs go inactive asynchronously; after release the display shows 0 and the pending value is lost.
- FP_DISPLAY_LZ_BLANK_EN defined, value 0x000000A5: digits 2-7 segments 0, digit1=0x77, digit0=0x6D; value 0 shows only digit0=0x3F. Repeat with SEG_ACTIVE_LOW=1 and check all outputs are bitwise inverted.
